// File: rtl/aes_round_ctrl_if.sv
// Control bundle between the AES round sequencer and the datapath/key schedule.
// The master side issues start/key_valid; the slave (the sequencer) drives the stage controls.
interface aes_round_ctrl_if;
   logic       start;
   logic       key_valid;
   logic       load_state;
   logic       enable_sub_bytes;
   logic       enable_shift_rows;
   logic       enable_mix_columns;
   logic       bypass_mix_columns;
   logic       enable_add_round_key;
   logic [3:0] round_num;
   logic       busy;
   logic       done;

   modport master (
      output start, key_valid,
      input  load_state, enable_sub_bytes, enable_shift_rows, enable_mix_columns,
             bypass_mix_columns, enable_add_round_key, round_num, busy, done
   );

   modport slave (
      input  start, key_valid,
      output load_state, enable_sub_bytes, enable_shift_rows, enable_mix_columns,
             bypass_mix_columns, enable_add_round_key, round_num, busy, done
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES encryption datapath: walks ARK0 then
// NUM_ROUNDS x (SB, SR, MC, ARK), stalling in ARK0/ARK until the round key is valid.
module aes_round_ctrl #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic            i_clk,
   input  logic            i_rst,
   aes_round_ctrl_if.slave io_ctl
);

   localparam logic [3:0] LP_LAST = 4'(NUM_ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE, S_ARK0, S_SB, S_SR, S_MC, S_ARK, S_DONE
   } state_t;

   state_t     r_state, w_next;
   logic [3:0] r_round, w_round_next;

   logic       w_load, w_sb, w_sr, w_mc, w_byp, w_ark, w_busy, w_done;
   logic [3:0] w_round_num;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= S_IDLE;
         r_round <= '0;
      end else begin
         r_state <= w_next;
         r_round <= w_round_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_round_next = r_round;
      w_load       = 1'b0;
      w_sb         = 1'b0;
      w_sr         = 1'b0;
      w_mc         = 1'b0;
      w_byp        = 1'b0;
      w_ark        = 1'b0;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      w_round_num  = 4'd0;
      case (r_state)
         S_IDLE: begin
            if (io_ctl.start) begin
               w_next       = S_ARK0;
               w_round_next = 4'd0;
            end
         end
         S_ARK0: begin
            w_load      = 1'b1;
            w_busy      = 1'b1;
            w_round_num = r_round;
            if (io_ctl.key_valid) begin
               w_ark        = 1'b1;
               w_round_next = 4'd1;
               w_next       = S_SB;
            end
         end
         S_SB: begin
            w_sb        = 1'b1;
            w_busy      = 1'b1;
            w_round_num = r_round;
            w_next      = S_SR;
         end
         S_SR: begin
            w_sr        = 1'b1;
            w_busy      = 1'b1;
            w_round_num = r_round;
            w_next      = S_MC;
         end
         S_MC: begin
            // Final round skips MixColumns: the register passes its input through.
            w_mc        = (r_round != LP_LAST);
            w_byp       = (r_round == LP_LAST);
            w_busy      = 1'b1;
            w_round_num = r_round;
            w_next      = S_ARK;
         end
         S_ARK: begin
            w_busy      = 1'b1;
            w_round_num = r_round;
            if (io_ctl.key_valid) begin
               w_ark = 1'b1;
               if (r_round == LP_LAST) begin
                  w_next = S_DONE;
               end else begin
                  w_round_next = r_round + 4'd1;
                  w_next       = S_SB;
               end
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_round_next = 4'd0;
            w_next       = S_IDLE;
         end
         default: begin
            w_next       = S_IDLE;
            w_round_next = 4'd0;
         end
      endcase
   end

   assign io_ctl.load_state           = w_load;
   assign io_ctl.enable_sub_bytes     = w_sb;
   assign io_ctl.enable_shift_rows    = w_sr;
   assign io_ctl.enable_mix_columns   = w_mc;
   assign io_ctl.bypass_mix_columns   = w_byp;
   assign io_ctl.enable_add_round_key = w_ark;
   assign io_ctl.round_num            = w_round_num;
   assign io_ctl.busy                 = w_busy;
   assign io_ctl.done                 = w_done;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: cycle-exact control sequence, key stalls, ignored starts,
// mid-run reset, back-to-back operation, and an AES-128 reference datapath driven by the enables.
module tb_aes_round_ctrl;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic clk = 1'b0;
   logic rst_a, rst_b;
   always #5 clk = ~clk;

   aes_round_ctrl_if ifa ();
   aes_round_ctrl_if ifb ();

   aes_round_ctrl #(.NUM_ROUNDS(10)) dut_a (.i_clk(clk), .i_rst(rst_a), .io_ctl(ifa.slave));
   aes_round_ctrl #(.NUM_ROUNDS(1))  dut_b (.i_clk(clk), .i_rst(rst_b), .io_ctl(ifb.slave));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- AES-128 reference ----------------
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      logic [7:0] base = x;
      logic [7:0] e = 8'd254;
      logic [7:0] s, r;
      for (int i = 0; i < 8; i++) begin
         if (e[0]) inv = gmul(inv, base);
         base = gmul(base, base);
         e = e >> 1;
      end
      if (x == 8'h00) inv = 8'h00;
      s = inv;
      r = inv;
      for (int i = 0; i < 4; i++) begin
         r = {r[6:0], r[7]};
         s = s ^ r;
      end
      return s ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-8*(4*c)   -: 8];
         a1 = s[127-8*(4*c+1) -: 8];
         a2 = s[127-8*(4*c+2) -: 8];
         a3 = s[127-8*(4*c+3) -: 8];
         o[127-8*(4*c)   -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
         o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
         o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
         o[127-8*(4*c+3) -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
      end
      return o;
   endfunction

   logic [127:0] rk [0:10];
   logic [127:0] st;

   initial begin
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      logic [127:0] k;
      k  = KEY;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   end

   // Datapath stand-in: one state register updated by whichever stage the controller enables.
   always @(posedge clk) begin
      if (ifa.enable_add_round_key)
         st <= (ifa.load_state ? PT : st) ^ rk[ifa.round_num];
      else if (ifa.enable_sub_bytes)
         st <= sub_bytes(st);
      else if (ifa.enable_shift_rows)
         st <= shift_rows(st);
      else if (ifa.enable_mix_columns)
         st <= mix_columns(st);
   end

   // ---------------- control expectations ----------------
   function automatic logic [11:0] vec_a();
      return {ifa.load_state, ifa.enable_sub_bytes, ifa.enable_shift_rows, ifa.enable_mix_columns,
              ifa.bypass_mix_columns, ifa.enable_add_round_key, ifa.round_num, ifa.busy, ifa.done};
   endfunction

   function automatic logic [11:0] mk(input logic ld, sb, sr, mc, byp, ark,
                                      input logic [3:0] rn, input logic bsy, dn);
      return {ld, sb, sr, mc, byp, ark, rn, bsy, dn};
   endfunction

   // Expected outputs k cycles after E0 with key_valid held high.
   function automatic logic [11:0] exp_k(input int k, input int n);
      int r, ph;
      if (k == 0) return mk(1, 0, 0, 0, 0, 1, 4'd0, 1, 0);
      if (k <= 4 * n) begin
         r  = (k - 1) / 4 + 1;
         ph = (k - 1) % 4;
         case (ph)
            0:       return mk(0, 1, 0, 0, 0, 0, 4'(r), 1, 0);
            1:       return mk(0, 0, 1, 0, 0, 0, 4'(r), 1, 0);
            2:       return mk(0, 0, 0, r != n, r == n, 0, 4'(r), 1, 0);
            default: return mk(0, 0, 0, 0, 0, 1, 4'(r), 1, 0);
         endcase
      end
      if (k == 4 * n + 1) return mk(0, 0, 0, 0, 0, 0, 4'd0, 0, 1);
      return 12'h000;
   endfunction

   task automatic run_op(input string nm, input int stall_k, input int stall_n,
                         input int poke1, input int poke2, input bit seq,
                         output int lat, output int nd);
      ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      lat = -1;
      nd  = 0;
      for (int k = 0; k < 80; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         ifa.key_valid = !(k >= stall_k && k < stall_k + stall_n);
         ifa.start     = (k == poke1 || k == poke2);
         #1;
         if (seq) chk($sformatf("%s_k%0d", nm, k), 128'(vec_a()), 128'(exp_k(k, 10)));
         if (k >= stall_k && k < stall_k + stall_n)
            chk($sformatf("%s_stall_k%0d", nm, k), 128'(vec_a()), 128'(mk(0, 0, 0, 0, 0, 0, 4'd4, 1, 0)));
         if (ifa.done) begin
            nd++;
            if (lat < 0) begin
               lat = k;
               chk({nm, "_ciphertext"}, st, CT);
            end
         end
         if (lat >= 0 && k >= lat + 8) break;
      end
      ifa.start     = 1'b0;
      ifa.key_valid = 1'b1;
   endtask

   initial begin
      int lat, nd, last, nb, nmc, nbyp;
      ifa.start = 1'b0; ifa.key_valid = 1'b1;
      ifb.start = 1'b0; ifb.key_valid = 1'b1;
      rst_a = 1'b0; rst_b = 1'b0;

      // Reset with start asserted: nothing may move.
      ifa.start = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("reset_outs", 128'(vec_a()), 128'(0));
      @(posedge clk); #1;
      chk("reset_hold", 128'(vec_a()), 128'(0));
      ifa.start = 1'b0;
      rst_a = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", 128'(vec_a()), 128'(0));

      run_op("nominal", 999, 0, -1, -1, 1'b1, lat, nd);
      chk("nominal_latency", 128'(lat), 128'(41));
      chk("nominal_ndone", 128'(nd), 128'(1));

      run_op("stall", 16, 3, -1, -1, 1'b0, lat, nd);
      chk("stall_latency", 128'(lat), 128'(44));

      run_op("poke", 999, 0, 21, 41, 1'b0, lat, nd);
      chk("poke_latency", 128'(lat), 128'(41));
      chk("poke_ndone", 128'(nd), 128'(1));
      chk("poke_not_queued", 128'(ifa.busy), 128'(0));

      // Reset during round-7 ShiftRows abandons the run.
      ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      for (int k = 1; k <= 26; k++) begin @(posedge clk); #1; end
      chk("pre_reset_sr7", 128'(vec_a()), 128'(exp_k(26, 10)));
      rst_a = 1'b0;
      @(posedge clk); #1;
      chk("midrun_reset", 128'(vec_a()), 128'(0));
      rst_a = 1'b1;
      @(posedge clk); #1;
      chk("midrun_reset_idle", 128'(vec_a()), 128'(0));
      run_op("fresh", 999, 0, -1, -1, 1'b0, lat, nd);
      chk("fresh_latency", 128'(lat), 128'(41));
      chk("fresh_ndone", 128'(nd), 128'(1));

      // Back-to-back on the single-round instance with start held high.
      rst_b = 1'b1;
      ifb.start = 1'b1;
      last = -1; nb = 0; nmc = 0; nbyp = 0;
      for (int c = 0; c < 60 && nb < 5; c++) begin
         @(posedge clk); #1;
         if (ifb.enable_mix_columns) nmc++;
         if (ifb.bypass_mix_columns) nbyp++;
         if (ifb.done) begin
            if (last >= 0) chk($sformatf("b2b_gap%0d", nb), 128'(c - last), 128'(7));
            last = c;
            nb++;
         end
      end
      ifb.start = 1'b0;
      chk("b2b_ndone", 128'(nb), 128'(5));
      chk("b2b_mc_enable", 128'(nmc), 128'(0));
      chk("b2b_bypass", 128'(nbyp), 128'(5));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
